// File: rtl/mul_sequencer.sv
// Multi-cycle signed sign-magnitude shift-add multiplier with BUSY/DONE handshake.
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mul_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [WIDTH-1:0]   DATA1,
  input  logic [WIDTH-1:0]   DATA2,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic [WIDTH-1:0]   RESULT,
  output logic               OVF
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic            neg_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [PW-1:0]   prod_q;
  logic [WIDTH-1:0] res_q;
  logic            ovf_q;

  logic [WIDTH-1:0] abs1_d;
  logic [WIDTH-1:0] abs2_d;
  logic [PW-1:0]   pp_d;
  logic [PW-1:0]   acc_d;
  logic [WIDTH-1:0] mplr_d;
  logic            last_d;
  logic [PW-1:0]   prod_d;
  logic [WIDTH:0]  top_d;
  logic            ovf_d;

  // |-128| wraps to 0x80, which is exactly 128 when read as unsigned
  assign abs1_d = DATA1[WIDTH-1] ? (~DATA1 + 1'b1) : DATA1;
  assign abs2_d = DATA2[WIDTH-1] ? (~DATA2 + 1'b1) : DATA2;

  assign pp_d   = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
  assign acc_d  = mplr_q[0] ? (acc_q + pp_d) : acc_q;
  assign mplr_d = mplr_q >> 1;

`ifdef MUL_EARLY_EXIT_EN
  assign last_d = (cnt_q == LAST) || (mplr_d == '0);
`else
  assign last_d = (cnt_q == LAST);
`endif

  assign prod_d = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign top_d  = prod_d[PW-1:WIDTH-1];
  assign ovf_d  = !((&top_d) || (~|top_d));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (START) begin
            mcand_q <= abs1_d;
            mplr_q  <= abs2_d;
            neg_q   <= DATA1[WIDTH-1] ^ DATA2[WIDTH-1];
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          mplr_q <= mplr_d;
          cnt_q  <= cnt_q + 1'b1;
          if (last_d) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          prod_q  <= prod_d;
          res_q   <= prod_d[WIDTH-1:0];
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PRODUCT = prod_q;
  assign RESULT  = res_q;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized self-checking bench for mul_sequencer against an arithmetic model.
// Honours MUL_EARLY_EXIT_EN when predicting latency.
module tb_mul_sequencer;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [7:0]  DATA1;
  logic [7:0]  DATA2;
  logic        BUSY;
  logic        DONE;
  logic [15:0] PRODUCT;
  logic [7:0]  RESULT;
  logic        OVF;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] last_p = 16'h0;

  mul_sequencer #(.WIDTH(8)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .START(START),
    .DATA1(DATA1),
    .DATA2(DATA2),
    .BUSY(BUSY),
    .DONE(DONE),
    .PRODUCT(PRODUCT),
    .RESULT(RESULT),
    .OVF(OVF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int m_prod(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return sa * sb;
  endfunction

  function automatic logic m_ovf(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = m_prod(a, b);
    return (p > 127) || (p < -128);
  endfunction

  function automatic int m_lat(input logic [7:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int m;
    int k;
    m = int'($signed(b));
    if (m < 0) m = -m;
    k = 0;
    for (int i = 0; i < 8; i++)
      if (((m >> i) & 1) == 1) k = i;
    return 2 + k;
`else
    return (b === b) ? 9 : 9;
`endif
  endfunction

  // Runs one operation; reports observed latency and handshake anomalies
  task automatic do_op(
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output int          lat,
    output logic        ctl_bad,
    output logic [15:0] p_acc,
    output logic [15:0] p,
    output logic [7:0]  r,
    output logic        o
  );
    DATA1 = a;
    DATA2 = b;
    START = 1'b1;
    @(posedge CLK); #1;
    ctl_bad = !BUSY || DONE;
    p_acc = PRODUCT;
    lat = -1;
    p = 16'hxxxx;
    r = 8'hxx;
    o = 1'bx;
    for (int i = 1; i <= 30; i++) begin
      START = 1'($urandom);
      DATA1 = 8'($urandom);
      DATA2 = 8'($urandom);
      @(posedge CLK); #1;
      if (DONE) begin
        lat = i;
        break;
      end
      if (!BUSY) ctl_bad = 1'b1;
    end
    START = 1'b0;
    if (lat > 0) begin
      if (BUSY) ctl_bad = 1'b1;
      p = PRODUCT;
      r = RESULT;
      o = OVF;
      @(posedge CLK); #1;
      if (DONE || BUSY) ctl_bad = 1'b1;
      if (PRODUCT !== p) ctl_bad = 1'b1;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    START = 1'b0;
    DATA1 = 8'($urandom);
    DATA2 = 8'($urandom);
    #3;
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got %b want 0", BUSY);
    end
    n_cmp++;
    if (DONE !== 1'b0) begin
      n_bad++; $display("FAIL reset_done got %b want 0", DONE);
    end
    n_cmp++;
    if (PRODUCT !== 16'h0) begin
      n_bad++; $display("FAIL reset_product got %h want 0000", PRODUCT);
    end
    n_cmp++;
    if (RESULT !== 8'h0) begin
      n_bad++; $display("FAIL reset_result got %h want 00", RESULT);
    end
    n_cmp++;
    if (OVF !== 1'b0) begin
      n_bad++; $display("FAIL reset_ovf got %b want 0", OVF);
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    n_cmp++;
    if ({BUSY, DONE} !== 2'b00) begin
      n_bad++; $display("FAIL post_reset_ctl got %b want 00", {BUSY, DONE});
    end
  endtask

  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic bad;
    logic [15:0] pa;
    logic [15:0] p;
    logic [7:0] r;
    logic o;
    logic [15:0] ep;
    ep = 16'(m_prod(a, b));
    do_op(a, b, lat, bad, pa, p, r, o);
    n_cmp++;
    if (lat !== m_lat(b)) begin
      n_bad++; $display("FAIL %s_lat a=%h b=%h got %0d want %0d", tag, a, b, lat, m_lat(b));
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++; $display("FAIL %s_handshake a=%h b=%h got bad=%b want 0", tag, a, b, bad);
    end
    n_cmp++;
    if (pa !== last_p) begin
      n_bad++; $display("FAIL %s_hold_on_accept got %h want %h", tag, pa, last_p);
    end
    n_cmp++;
    if (p !== ep) begin
      n_bad++; $display("FAIL %s_product a=%h b=%h got %h want %h", tag, a, b, p, ep);
    end
    n_cmp++;
    if (r !== ep[7:0]) begin
      n_bad++; $display("FAIL %s_result a=%h b=%h got %h want %h", tag, a, b, r, ep[7:0]);
    end
    n_cmp++;
    if (o !== m_ovf(a, b)) begin
      n_bad++; $display("FAIL %s_ovf a=%h b=%h got %b want %b", tag, a, b, o, m_ovf(a, b));
    end
    last_p = ep;
  endtask

  task automatic test_directed;
    logic [7:0] ta [8] = '{8'd5, 8'hF9, 8'h80, 8'h80, 8'd100, 8'd3, 8'd3, 8'h00};
    logic [7:0] tb [8] = '{8'd3, 8'd6, 8'h80, 8'h01, 8'd2, 8'd0, 8'h80, 8'h7F};
    for (int i = 0; i < 8; i++) check_op("dir", ta[i], tb[i]);
  endtask

  task automatic test_random;
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 7 == 0) a = 8'h80;
      if (i % 5 == 0) b = 8'($urandom_range(0, 3));
      check_op("rnd", a, b);
    end
  endtask

  task automatic test_idle_hold;
    logic bad;
    bad = 1'b0;
    START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      DATA1 = 8'($urandom);
      DATA2 = 8'($urandom);
      @(posedge CLK); #1;
      if (BUSY || DONE || PRODUCT !== last_p) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++; $display("FAIL idle_hold got PRODUCT=%h BUSY=%b want %h/0", PRODUCT, BUSY, last_p);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a1, b1, a2, b2;
    int l1, l2, nd;
    a1 = 8'($urandom);
    b1 = 8'($urandom_range(64, 127));
    a2 = 8'($urandom);
    b2 = 8'($urandom);
    l1 = m_lat(b1);
    l2 = m_lat(b2);
    nd = 0;
    DATA1 = a1;
    DATA2 = b1;
    START = 1'b1;
    @(posedge CLK); #1;
    for (int i = 1; i <= l1 + l2 + 6; i++) begin
      @(posedge CLK); #1;
      if (i == 3) begin
        DATA1 = a2;
        DATA2 = b2;
      end
      if (i == l1 + 1) START = 1'b0;
      if (DONE) begin
        nd++;
        if (nd == 1) begin
          n_cmp++;
          if (i !== l1 || PRODUCT !== 16'(m_prod(a1, b1))) begin
            n_bad++;
            $display("FAIL b2b_first got cyc=%0d p=%h want cyc=%0d p=%h",
                     i, PRODUCT, l1, 16'(m_prod(a1, b1)));
          end
        end
        if (nd == 2) begin
          n_cmp++;
          if (i !== l1 + 1 + l2 || PRODUCT !== 16'(m_prod(a2, b2))) begin
            n_bad++;
            $display("FAIL b2b_second got cyc=%0d p=%h want cyc=%0d p=%h",
                     i, PRODUCT, l1 + 1 + l2, 16'(m_prod(a2, b2)));
          end
        end
      end
    end
    START = 1'b0;
    n_cmp++;
    if (nd !== 2) begin
      n_bad++; $display("FAIL b2b_done_count got %0d want 2", nd);
    end
    last_p = 16'(m_prod(a2, b2));
  endtask

  task automatic test_reset_mid;
    logic seen;
    DATA1 = 8'h7F;
    DATA2 = 8'h81;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
    #1;
    n_cmp++;
    if ({BUSY, DONE, OVF} !== 3'b000 || PRODUCT !== 16'h0 || RESULT !== 8'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs got busy=%b done=%b ovf=%b p=%h r=%h want all 0",
               BUSY, DONE, OVF, PRODUCT, RESULT);
    end
    #2;
    RESET = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL midreset_no_done got activity=%b want 0", seen);
    end
    last_p = 16'h0;
    check_op("post_rst", 8'($urandom), 8'($urandom));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_hold();
    test_random();
    test_back_to_back();
    test_idle_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle signed 8x8 multiply engine for the 8-bit CPU datapath; replaces the combinational multiplier on the ALU MUL path.
- Sign-magnitude shift-add: absolute values of both operands, one partial product per cycle, sign correction at the end.
- Provides a BUSY stall signal to the CPU control unit and a one-cycle DONE pulse with the result.

Parameters:
- WIDTH, 8, operand width in bits; the product is 2*WIDTH bits. Only 8 is verified.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- START  in  1  request; sampled only in IDLE.
- DATA1  in  8  multiplicand, two's complement; captured on the accepting edge.
- DATA2  in  8  multiplier, two's complement; captured on the accepting edge.
- BUSY  out  1  high while an operation is in flight; CPU stalls on it.
- DONE  out  1  one-cycle pulse; PRODUCT and RESULT are valid from this cycle.
- PRODUCT  out  16  full signed product.
- RESULT  out  8  PRODUCT[7:0], the value written back to the register file.
- OVF  out  1  high when PRODUCT does not fit in signed 8 bits, i.e. PRODUCT[15:7] not all equal.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; BUSY=0, DONE=0, PRODUCT=0, RESULT=0, OVF=0; all internal registers cleared.
- States: IDLE, CALC, FIX.
- IDLE, START=1 at edge E0:
  - Capture mcand=|DATA1| and mplr=|DATA2| as 8-bit unsigned (|-128| = 128).
  - Capture neg = DATA1[7] ^ DATA2[7]; clear acc(16) and count(3).
  - BUSY=1; go to CALC.
- IDLE, START=0: hold all outputs.
- CALC, edges E1..E8, one bit per edge:
  - If mplr[0]=1: acc = acc + (mcand << count), with a 16-bit add.
  - mplr = mplr >> 1; count = count + 1.
  - After the edge where count was 7: go to FIX.
- FIX, edge E9:
  - PRODUCT = neg ? (~acc + 1) : acc.
  - Register RESULT and OVF from the new PRODUCT.
  - DONE=1, BUSY=0; go to IDLE.
- Next edge: DONE=0.
- Latency: START accepted at E0 gives DONE high between E9 and E10. Earliest next acceptance is E10. BUSY is high from E0 to E9.
- START while BUSY=1 (including on E9) is ignored. DATA1 and DATA2 changing mid-operation have no effect.
- PRODUCT, RESULT and OVF hold their values until the FIX edge of the next operation. They do not change on acceptance.
- Zero operand: PRODUCT=0 and neg is irrelevant, since -0 = 0 in 16 bits.
- Reset mid-operation: aborts immediately, no DONE; outputs return to their reset values.
- Arithmetic: acc never exceeds 128*128 = 16384, so no internal overflow and no carry-out is kept.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - In CALC, if the shifted mplr is 0 after an edge, go to FIX on the next edge, regardless of count.
  - DONE then occurs at edge E(2+k), where k is the index of the highest set bit of |DATA2| (k=0 when DATA2=0 or |DATA2|=1). Max remains E9.
  - Results are identical to the undefined case.
- Undefined: fixed 9-cycle latency as above; early-exit logic is absent.

Test Plan:
- DATA1=5, DATA2=3, START at E0 -> BUSY=1 during E0..E9; DONE at E9; PRODUCT=0x000F, RESULT=0x0F, OVF=0.
- DATA1=-7 (0xF9), DATA2=6 -> PRODUCT=0xFFD6, RESULT=0xD6, OVF=0.
- DATA1=0x80, DATA2=0x80 (-128*-128) -> PRODUCT=0x4000, RESULT=0x00, OVF=1; also 0x80*0x01 -> PRODUCT=0xFF80, OVF=0.
- START held high continuously with DATA changed at E3 -> exactly one DONE at E9 using the E0 operands; second acceptance at E10, DONE at E19.
- RESET=0 pulsed between E4 and E5 mid-operation -> all outputs 0 immediately, no DONE pulse; a new START afterwards completes normally.
- With MUL_EARLY_EXIT_EN: 100*2 -> DONE at E3, PRODUCT=0x00C8; 3*0 -> DONE at E2, PRODUCT=0; 3*-128 -> DONE at E9, PRODUCT=0xFE80.
